msu_data_reader: RTL and testbench
==================================

// Module: msu_data_reader
// PURPOSE
//  Memory-side responder for the MSU-1 data-track port. Serves the MSU register block's seek/read requests.
//  Fetches 64-bit qwords of the data file (e.g. .msu) from DDRAM. Presents one byte on msu_data_in.
//  Keeps a current qword plus one prefetched qword, so sequential $2001 reads never wait on DDRAM.
//  Sits between the MSU register block and the DDRAM arbiter port.
// PARAMETERS
//  BASE_QW   29'h0   DDRAM qword address of data file byte 0
//  DDR_AW    29      DDRAM qword address width
// PORTS
//  CLK             in   1   system clock
//  RST_N           in   1   reset, asynchronous, active-low
//  msu_data_addr   in   32  byte address; sampled only on seek detect
//  msu_data_seek   in   1   level; high from $2003 write until MSU sees ack rise
//  msu_data_req    in   1   1-cycle pulse: byte consumed, advance 1
//  msu_data_size   in   32  data file length in bytes
//  msu_data_in     out  8   current byte
//  msu_data_ack    out  1   low while seek in progress; rising edge = seek done
//  ddr_rd          out  1   read request, held until accepted
//  ddr_addr        out  29  qword address = BASE_QW + ptr[31:3]
//  ddr_burstcnt    out  8   constant 1
//  ddr_busy        in   1   arbiter stall; read accepted when ddr_rd & ~ddr_busy
//  ddr_dout        in   64  read data, byte k = ddr_dout[8k+7:8k]
//  ddr_dout_ready  in   1   1-cycle pulse, ddr_dout valid
// BEHAVIOUR
//  Reset values: msu_data_in=0, msu_data_ack=0, ddr_rd=0, ddr_addr=0. Internal state: IDLE, cur/next invalid, ptr=0.
//  Max one outstanding DDRAM read. Responses are tagged internally with the requested qword index.
//  Seek detect: seek rising edge, OR seek=1 while msu_data_addr != latched seek address.
//  On seek detect:
//   - ptr <= msu_data_addr; ack <= 0; cur/next invalid; state SEEK.
//  States:
//   IDLE   - no valid data; waits for seek.
//   SEEK   - issue read of ptr qword.
//            Cur valid & tag==ptr[31:3] -> msu_data_in updates, PREF.
//            Ack rises on the cycle after msu_data_in updates. Ack is low for >=2 cycles per seek.
//   PREF   - issue read of cur tag+1 into next -> READY.
//   READY  - serve reqs from cur/next.
//   STALL  - cur needed, fetch outstanding; ack stays 1.
//  On msu_data_req: ptr <= ptr+1. msu_data_in updates the next cycle.
//   - ptr[2:0] 7->0 with next valid: cur <= next; next invalid; prefetch qword+1 (PREF).
//   - ptr[2:0] 7->0 with next invalid: STALL. Byte is driven 1 cycle after the matching response.
//  Tag mismatch rule: a response whose tag != wanted qword is discarded and the wanted qword is re-read.
//   - Covers reqs during STALL and seeks with a read in flight.
//   - A seek with a read outstanding waits for that response, discards it, then reads the new ptr.
//  EOF: ptr >= msu_data_size -> msu_data_in = 8'h00. No fetch is issued for qwords wholly past EOF.
//  ptr wraps 32'hFFFFFFFF -> 0. ddr_addr is a DDR_AW-bit sum, so it wraps mod 2^DDR_AW.
//  Simultaneous seek + req: seek wins; req ignored.
//  Simultaneous response + seek: response discarded.
//  Async reset mid-operation: all state to reset values. Responses arriving in IDLE are ignored.
// TESTING
//  1 seek addr=0x0, mem qw0=0x0706050403020100 -> ack 0 then 1; data_in=0x00; 7 reqs step data_in to 0x07.
//  2 seek 0x5, 3 reqs (cross 7->8) with next prefetched -> data_in 05,06,07,08; no STALL; one new ddr_rd (qw2).
//  3 ddr_busy held 20 cycles on seek -> ddr_rd held steady 20 cycles; ack stays 0 until data; no duplicate read.
//  4 reseek to 0x100 while qw0 read outstanding -> old response discarded; data_in = byte 0x100; one ack rise.
//  5 size=0x9, seek 0x8, 2 reqs -> data_in = byte8, then 0x00; no ddr_rd for qw2.
//  6 assert RST_N low mid-STALL, release; response arrives -> outputs stay at reset values, state IDLE.

Source files
------------

// File: rtl/msu_data_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : msu_data_reader_if
//  Description : Bundles the MSU register-block side (seek/read requests and
//                the returned byte) with the DDRAM arbiter read port used by
//                msu_data_reader.
//                slave  = the reader itself
//                master = everything around it (MSU block + DDRAM arbiter)
//  Revision    : 1.0  initial release
// ============================================================================
interface msu_data_reader_if #(
   parameter int DDR_AW = 29
);
   // MSU register block side
   logic [31:0]       msu_data_addr;
   logic              msu_data_seek;
   logic              msu_data_req;
   logic [31:0]       msu_data_size;
   logic [7:0]        msu_data_in;
   logic              msu_data_ack;

   // DDRAM arbiter side
   logic              ddr_rd;
   logic [DDR_AW-1:0] ddr_addr;
   logic [7:0]        ddr_burstcnt;
   logic              ddr_busy;
   logic [63:0]       ddr_dout;
   logic              ddr_dout_ready;

   modport slave (
      input  msu_data_addr, msu_data_seek, msu_data_req, msu_data_size,
      input  ddr_busy, ddr_dout, ddr_dout_ready,
      output msu_data_in, msu_data_ack,
      output ddr_rd, ddr_addr, ddr_burstcnt
   );

   modport master (
      output msu_data_addr, msu_data_seek, msu_data_req, msu_data_size,
      output ddr_busy, ddr_dout, ddr_dout_ready,
      input  msu_data_in, msu_data_ack,
      input  ddr_rd, ddr_addr, ddr_burstcnt
   );
endinterface
`default_nettype wire

// File: rtl/msu_data_reader.sv
`default_nettype none
// ============================================================================
//  Module      : msu_data_reader
//  Description : Memory-side responder for the MSU-1 data-track port.
//                Holds the qword containing the current byte ("cur") plus a
//                prefetched following qword ("next"), so sequential byte
//                reads do not wait on DDRAM. At most one DDRAM read is in
//                flight; responses are matched against the qword index they
//                were requested for and dropped when no longer wanted.
//  Revision    : 1.0  initial release
// ============================================================================
module msu_data_reader #(
   parameter int                DDR_AW  = 29,
   parameter logic [DDR_AW-1:0] BASE_QW = '0
) (
   input  wire logic        CLK,
   input  wire logic        RST_N,
   msu_data_reader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,   // nothing valid, waiting for a seek
      S_SEEK  = 3'd1,   // fetching the qword a seek landed in
      S_PREF  = 3'd2,   // launch prefetch of the qword after cur
      S_READY = 3'd3,   // serving byte requests
      S_STALL = 3'd4    // crossed into a qword that is not on chip yet
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t              state;
   logic [31:0]         ptr;          // byte address of the presented byte
   logic [31:0]         seek_addr;    // address latched by the last seek
   logic                seek_d;       // previous seek level for edge detect

   logic                cur_valid;
   logic [28:0]         cur_tag;
   logic [63:0]         cur_data;
   logic                next_valid;
   logic [28:0]         next_tag;
   logic [63:0]         next_data;

   logic                pend;         // a DDRAM read is requested or in flight
   logic [28:0]         pend_tag;     // qword index of that read
   logic                stale;        // in-flight read predates the last seek
   logic                ack_pend;     // raise ack one cycle after the byte

   logic [7:0]          byte_out;
   logic                ack;
   logic                rd;
   logic [DDR_AW-1:0]   rd_addr;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [28:0]         qw;
   logic [31:0]         ptr_inc;
   logic [28:0]         qw_inc;
   logic [28:0]         cur_tag_inc;
   logic                cur_hit;
   logic                inc_eof;
   logic                pref_gone;
   logic                seek_det;
   logic                accept;
   logic                resp;
   logic                resp_cur;
   logic                resp_next;

   // In SEEK/STALL the fill logic looks at the address the byte will have
   // after this cycle's request, so a request during STALL is never lost.
   logic [31:0]         fill_ptr;
   logic [28:0]         fill_qw;
   logic                fill_hit;
   logic                fill_eof;
   logic                fill_gone;
   logic                fill_promote;

   assign qw          = ptr[31:3];
   assign ptr_inc     = ptr + 32'd1;
   assign qw_inc      = qw + 29'd1;
   assign cur_tag_inc = cur_tag + 29'd1;
   assign cur_hit     = cur_valid && (cur_tag == qw);
   assign inc_eof     = (ptr_inc >= bus.msu_data_size);
   // a qword is skipped only when its first byte is already past EOF
   assign pref_gone   = ({cur_tag_inc, 3'b000} >= bus.msu_data_size);

   assign seek_det    = bus.msu_data_seek &&
                        (!seek_d || (bus.msu_data_addr != seek_addr));
   assign accept      = rd && !bus.ddr_busy;
   // a response only counts once our read has been accepted
   assign resp        = bus.ddr_dout_ready && pend && !rd;
   assign resp_cur    = resp && !stale && (pend_tag == qw) && !cur_hit;
   assign resp_next   = resp && !stale && !resp_cur && cur_valid &&
                        !next_valid && (pend_tag == cur_tag_inc);

   assign fill_ptr     = (state == S_STALL && bus.msu_data_req) ? ptr_inc : ptr;
   assign fill_qw      = fill_ptr[31:3];
   assign fill_hit     = cur_valid && (cur_tag == fill_qw);
   assign fill_eof     = (fill_ptr >= bus.msu_data_size);
   assign fill_gone    = ({fill_qw, 3'b000} >= bus.msu_data_size);
   assign fill_promote = next_valid && (next_tag == fill_qw);

   // byte k of a qword lives in bits [8k+7:8k]
   function automatic logic [7:0] pick(input logic [63:0] q, input logic [2:0] k);
      return q[{k, 3'b000} +: 8];
   endfunction

   // qword index to DDRAM address; the sum wraps at DDR_AW bits
   function automatic logic [DDR_AW-1:0] qw_addr(input logic [28:0] tag);
      return BASE_QW + DDR_AW'(tag);
   endfunction

   // ------------------------------------------------------------------------
   // Seek handling, qword buffering, DDRAM read issue and byte presentation
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= S_IDLE;
         ptr        <= '0;
         seek_addr  <= '0;
         seek_d     <= 1'b0;
         cur_valid  <= 1'b0;
         cur_tag    <= '0;
         cur_data   <= '0;
         next_valid <= 1'b0;
         next_tag   <= '0;
         next_data  <= '0;
         pend       <= 1'b0;
         pend_tag   <= '0;
         stale      <= 1'b0;
         ack_pend   <= 1'b0;
         byte_out   <= 8'h00;
         ack        <= 1'b0;
         rd         <= 1'b0;
         rd_addr    <= '0;
      end else begin
         seek_d <= bus.msu_data_seek;

         if (accept) rd <= 1'b0;
         if (resp)   pend <= 1'b0;

         if (ack_pend) begin
            ack      <= 1'b1;
            ack_pend <= 1'b0;
         end

         if (seek_det) begin
            // a seek wins over a same-cycle request or response
            ptr        <= bus.msu_data_addr;
            seek_addr  <= bus.msu_data_addr;
            ack        <= 1'b0;
            ack_pend   <= 1'b0;
            cur_valid  <= 1'b0;
            next_valid <= 1'b0;
            stale      <= pend && !resp;
            state      <= S_SEEK;
         end else begin
            if (resp) stale <= 1'b0;

            if (resp_cur) begin
               cur_data  <= bus.ddr_dout;
               cur_tag   <= pend_tag;
               cur_valid <= 1'b1;
            end
            if (resp_next) begin
               next_data  <= bus.ddr_dout;
               next_tag   <= pend_tag;
               next_valid <= 1'b1;
            end

            case (state)
               S_SEEK, S_STALL: begin
                  ptr <= fill_ptr;
                  if (fill_hit) begin
                     byte_out <= fill_eof ? 8'h00 : pick(cur_data, fill_ptr[2:0]);
                     state    <= S_PREF;
                     if (state == S_SEEK) ack_pend <= 1'b1;
                  end else if (fill_promote) begin
                     // prefetch landed in next just as we crossed into it
                     cur_data   <= next_data;
                     cur_tag    <= next_tag;
                     cur_valid  <= 1'b1;
                     next_valid <= 1'b0;
                  end else if (!pend) begin
                     if (fill_gone) begin
                        byte_out <= 8'h00;
                        state    <= S_READY;
                        if (state == S_SEEK) ack_pend <= 1'b1;
                     end else begin
                        rd       <= 1'b1;
                        rd_addr  <= qw_addr(fill_qw);
                        pend     <= 1'b1;
                        pend_tag <= fill_qw;
                     end
                  end
               end

               S_PREF, S_READY: begin
                  if (state == S_PREF && !pend) begin
                     if (!next_valid && cur_valid && !pref_gone) begin
                        rd       <= 1'b1;
                        rd_addr  <= qw_addr(cur_tag_inc);
                        pend     <= 1'b1;
                        pend_tag <= cur_tag_inc;
                     end
                     state <= S_READY;
                  end

                  if (bus.msu_data_req) begin
                     ptr <= ptr_inc;
                     if (ptr[2:0] != 3'd7) begin
                        byte_out <= inc_eof ? 8'h00 : pick(cur_data, ptr_inc[2:0]);
                     end else if (next_valid && (next_tag == qw_inc)) begin
                        cur_data   <= next_data;
                        cur_tag    <= next_tag;
                        cur_valid  <= 1'b1;
                        next_valid <= 1'b0;
                        byte_out   <= inc_eof ? 8'h00 : next_data[7:0];
                        state      <= S_PREF;
                     end else begin
                        if (inc_eof) byte_out <= 8'h00;
                        state <= S_STALL;
                     end
                  end
               end

               default: ;   // S_IDLE: responses here have no owner
            endcase
         end
      end
   end

   assign bus.msu_data_in  = byte_out;
   assign bus.msu_data_ack = ack;
   assign bus.ddr_rd       = rd;
   assign bus.ddr_addr     = rd_addr;
   assign bus.ddr_burstcnt = 8'd1;

endmodule
`default_nettype wire

// File: tb/tb_msu_data_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msu_data_reader
//  Description : Directed bench for msu_data_reader with a small DDRAM model
//                (fixed latency, optional response hold).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_msu_data_reader;

   localparam int          DDR_AW = 29;
   localparam logic [28:0] BASE   = 29'h10;
   localparam int          LAT    = 3;

   logic CLK;
   logic RST_N;

   msu_data_reader_if #(.DDR_AW(DDR_AW)) bus();

   msu_data_reader #(.DDR_AW(DDR_AW), .BASE_QW(BASE)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   int          n_chk     = 0;
   int          n_err     = 0;
   int          cyc       = 0;
   int          ack_rises = 0;
   logic        ack_prev  = 1'b0;
   logic        hold      = 1'b0;
   logic [28:0] acc_log[$];
   logic [28:0] addr_q[$];
   int          due_q[$];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // file contents: byte at address a
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]};
   endfunction

   function automatic logic [63:0] mem_qw(input logic [28:0] idx);
      logic [63:0] q;
      for (int k = 0; k < 8; k++) q[8*k +: 8] = mem_byte({idx, 3'b000} + 32'(k));
      return q;
   endfunction

   function automatic int count_from(input int start, input logic [28:0] a);
      int n = 0;
      for (int i = start; i < acc_log.size(); i++) if (acc_log[i] == a) n++;
      return n;
   endfunction

   // DDRAM acceptance log and ack-rise monitor
   always @(posedge CLK) begin
      if (bus.ddr_rd && !bus.ddr_busy) begin
         acc_log.push_back(bus.ddr_addr);
         addr_q.push_back(bus.ddr_addr);
         due_q.push_back(cyc + LAT);
      end
      if (bus.msu_data_ack && !ack_prev) ack_rises++;
      ack_prev = bus.msu_data_ack;
      cyc++;
   end

   // DDRAM response model
   always @(negedge CLK) begin
      logic [28:0] a;
      int          d;
      bus.ddr_dout_ready = 1'b0;
      if (!hold && due_q.size() > 0 && cyc >= due_q[0]) begin
         a = addr_q.pop_front();
         d = due_q.pop_front();
         bus.ddr_dout       = mem_qw(a - BASE);
         bus.ddr_dout_ready = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input string tag, output int low);
      low = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         if (bus.msu_data_ack) break;
         low++;
      end
      chk(tag, 64'(bus.msu_data_ack), 64'd1);
   endtask

   task automatic do_req();
      bus.msu_data_req = 1'b1;
      @(negedge CLK);
      bus.msu_data_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      int low;
      int s;
      int r0;
      int steady;

      RST_N             = 1'b0;
      bus.msu_data_addr = '0;
      bus.msu_data_seek = 1'b0;
      bus.msu_data_req  = 1'b0;
      bus.msu_data_size = 32'h1000;
      bus.ddr_busy      = 1'b0;
      bus.ddr_dout      = '0;
      bus.ddr_dout_ready = 1'b0;
      idle(3);
      chk("rst_data_in", 64'(bus.msu_data_in), 64'h00);
      chk("rst_ack",     64'(bus.msu_data_ack), 64'd0);
      chk("rst_ddr_rd",  64'(bus.ddr_rd), 64'd0);
      chk("rst_ddr_addr", 64'(bus.ddr_addr), 64'd0);
      chk("burstcnt",    64'(bus.ddr_burstcnt), 64'd1);
      RST_N = 1'b1;
      idle(2);

      // 1: seek 0, then 7 sequential reads
      s = acc_log.size();
      bus.msu_data_addr = 32'h0;
      bus.msu_data_seek = 1'b1;
      wait_ack("t1_ack_rise", low);
      chk("t1_ack_low_min", 64'(low >= 2), 64'd1);
      chk("t1_data0", 64'(bus.msu_data_in), 64'h00);
      chk("t1_read_qw0", 64'(count_from(s, BASE)), 64'd1);
      bus.msu_data_seek = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         do_req();
         chk($sformatf("t1_step%0d", i), 64'(bus.msu_data_in), 64'(i));
      end

      // 2: seek 5, cross 7->8 using the prefetched qword
      bus.msu_data_addr = 32'h5;
      bus.msu_data_seek = 1'b1;
      wait_ack("t2_ack_rise", low);
      chk("t2_data5", 64'(bus.msu_data_in), 64'h05);
      bus.msu_data_seek = 1'b0;
      idle(10);
      s = acc_log.size();
      do_req();
      chk("t2_data6", 64'(bus.msu_data_in), 64'h06);
      do_req();
      chk("t2_data7", 64'(bus.msu_data_in), 64'h07);
      do_req();
      chk("t2_data8_nostall", 64'(bus.msu_data_in), 64'h08);
      idle(10);
      chk("t2_new_reads", 64'(acc_log.size() - s), 64'd1);
      chk("t2_read_qw2", 64'(count_from(s, BASE + 29'd2)), 64'd1);

      // 3: arbiter busy for 20 cycles during a seek
      s = acc_log.size();
      bus.ddr_busy      = 1'b1;
      bus.msu_data_addr = 32'h40;
      bus.msu_data_seek = 1'b1;
      idle(2);
      steady = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.ddr_rd && bus.ddr_addr == BASE + 29'd8 && !bus.msu_data_ack) steady++;
         @(negedge CLK);
      end
      chk("t3_rd_held", 64'(steady), 64'd20);
      chk("t3_none_accepted", 64'(acc_log.size() - s), 64'd0);
      bus.ddr_busy = 1'b0;
      wait_ack("t3_ack_rise", low);
      chk("t3_single_read", 64'(count_from(s, BASE + 29'd8)), 64'd1);
      chk("t3_data40", 64'(bus.msu_data_in), 64'h40);
      bus.msu_data_seek = 1'b0;
      idle(10);

      // 4: reseek to 0x100 while the qw0 read is still outstanding
      s  = acc_log.size();
      r0 = ack_rises;
      hold = 1'b1;
      bus.msu_data_addr = 32'h0;
      bus.msu_data_seek = 1'b1;
      idle(4);
      chk("t4_qw0_issued", 64'(count_from(s, BASE)), 64'd1);
      bus.msu_data_addr = 32'h100;
      idle(3);
      chk("t4_waits_old", 64'(bus.ddr_rd), 64'd0);
      chk("t4_ack_low", 64'(bus.msu_data_ack), 64'd0);
      hold = 1'b0;
      wait_ack("t4_ack_rise", low);
      chk("t4_data100", 64'(bus.msu_data_in), 64'h11);
      chk("t4_read_qw20", 64'(count_from(s, BASE + 29'h20)), 64'd1);
      @(negedge CLK);
      chk("t4_one_ack_rise", 64'(ack_rises - r0), 64'd1);
      bus.msu_data_seek = 1'b0;
      idle(10);

      // 5: EOF at 9 bytes, seek 8
      s = acc_log.size();
      bus.msu_data_size = 32'h9;
      bus.msu_data_addr = 32'h8;
      bus.msu_data_seek = 1'b1;
      wait_ack("t5_ack_rise", low);
      chk("t5_data8", 64'(bus.msu_data_in), 64'h08);
      bus.msu_data_seek = 1'b0;
      idle(10);
      do_req();
      chk("t5_eof_a", 64'(bus.msu_data_in), 64'h00);
      do_req();
      chk("t5_eof_b", 64'(bus.msu_data_in), 64'h00);
      idle(5);
      chk("t5_read_qw1", 64'(count_from(s, BASE + 29'd1)), 64'd1);
      chk("t5_no_qw2", 64'(count_from(s, BASE + 29'd2)), 64'd0);

      // 6: reset while stalled, late response must be ignored
      bus.msu_data_size = 32'h1000;
      bus.msu_data_addr = 32'h10;
      bus.msu_data_seek = 1'b1;
      wait_ack("t6_ack_rise", low);
      hold = 1'b1;
      bus.msu_data_seek = 1'b0;
      for (int i = 1; i <= 7; i++) do_req();
      chk("t6_data17", 64'(bus.msu_data_in), 64'h17);
      do_req();
      idle(3);
      chk("t6_stall_data", 64'(bus.msu_data_in), 64'h17);
      chk("t6_stall_ack", 64'(bus.msu_data_ack), 64'd1);
      RST_N = 1'b0;
      #1;
      chk("t6_rst_data", 64'(bus.msu_data_in), 64'h00);
      chk("t6_rst_ack",  64'(bus.msu_data_ack), 64'd0);
      chk("t6_rst_rd",   64'(bus.ddr_rd), 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      hold  = 1'b0;
      idle(10);
      chk("t6_resp_delivered", 64'(due_q.size()), 64'd0);
      chk("t6_post_data", 64'(bus.msu_data_in), 64'h00);
      chk("t6_post_ack",  64'(bus.msu_data_ack), 64'd0);
      chk("t6_post_rd",   64'(bus.ddr_rd), 64'd0);
      chk("t6_post_addr", 64'(bus.ddr_addr), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
